// File: rtl/window_scan_ctrl_if.sv
// Handshake bundle between the window scan controller and its memory/stage neighbours.
// The controller takes the master side; the surrounding datapath takes the slave side.
interface window_scan_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              in_mem_ready;
    logic              en_in_mem;
    logic [ADDR_W-1:0] in_mem_addr;
    logic              en_gray;
    logic [3:0]        gray_addr;
    logic              en_sobel;
    logic              en_shiftscale;
    logic              en_out_mem;
    logic [ADDR_W-1:0] out_mem_addr;
    logic              busy;
    logic              done;

    modport master (
        input  start, in_mem_ready,
        output en_in_mem, in_mem_addr, en_gray, gray_addr, en_sobel,
               en_shiftscale, en_out_mem, out_mem_addr, busy, done
    );

    modport slave (
        output start, in_mem_ready,
        input  en_in_mem, in_mem_addr, en_gray, gray_addr, en_sobel,
               en_shiftscale, en_out_mem, out_mem_addr, busy, done
    );
endinterface

// File: rtl/window_scan_ctrl.sv
// Raster-order 3x3 window scanner: sequences fetch/gray/sobel/scale/write per pixel.
// Optional BORDER_REPLICATE_EN clamps edge taps instead of pointing them at PAD_ADDR.
module window_scan_ctrl #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int ADDR_W   = 32,
    parameter int PAD_ADDR = IMG_W * IMG_H
) (
    input  logic                  clk,
    input  logic                  rst,
    window_scan_ctrl_if.master    bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = ((XW > YW) ? XW : YW) + 2;

    localparam logic [XW-1:0]        X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0]        Y_LAST  = YW'(IMG_H - 1);
    localparam logic signed [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic signed [CW-1:0] ROW_MAX = CW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0]    STRIDE  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0]    PAD     = ADDR_W'(PAD_ADDR);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_GRAY, S_SOBEL, S_SCALE, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [XW-1:0]            x;
    logic [YW-1:0]            y;
    logic [3:0]               gray_addr;
    logic [ADDR_W-1:0]        out_addr;
    logic                     last_pix;
    logic                     launch;
    logic [1:0]               kc, kr;
    logic signed [CW-1:0]     col_c, row_c;
    logic [ADDR_W-1:0]        tap_addr;

    function automatic logic signed [CW-1:0] clamp_coord(
        input logic signed [CW-1:0] v,
        input logic signed [CW-1:0] vmax
    );
        if (v[CW-1])      return '0;
        else if (v > vmax) return vmax;
        else               return v;
    endfunction

    function automatic logic out_of_range(
        input logic signed [CW-1:0] v,
        input logic signed [CW-1:0] vmax
    );
        return v[CW-1] || (v > vmax);
    endfunction

    assign last_pix = (x == X_LAST) && (y == Y_LAST);
    assign launch   = ((state == S_IDLE) || (state == S_DONE)) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_FETCH;
            S_FETCH: if (bus.in_mem_ready) state_nxt = S_GRAY;
            S_GRAY:  state_nxt = (gray_addr < 4'd8) ? S_FETCH : S_SOBEL;
            S_SOBEL: state_nxt = S_SCALE;
            S_SCALE: state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_NEXT;
            S_NEXT:  state_nxt = last_pix ? S_DONE : S_FETCH;
            S_DONE:  if (bus.start) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Scan counters: the last pixel leaves x/y parked until the next launch clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            gray_addr <= '0;
            out_addr  <= '0;
        end else if (launch) begin
            x         <= '0;
            y         <= '0;
            gray_addr <= '0;
            out_addr  <= '0;
        end else begin
            case (state)
                S_GRAY:  gray_addr <= gray_addr + 4'd1;
                S_SOBEL: gray_addr <= '0;
                S_WRITE: out_addr  <= out_addr + ADDR_W'(1);
                S_NEXT: begin
                    if (!last_pix) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        kc = 2'd0;
        kr = 2'd0;
        case (gray_addr)
            4'd0: {kr, kc} = 4'b00_00;
            4'd1: {kr, kc} = 4'b00_01;
            4'd2: {kr, kc} = 4'b00_10;
            4'd3: {kr, kc} = 4'b01_00;
            4'd4: {kr, kc} = 4'b01_01;
            4'd5: {kr, kc} = 4'b01_10;
            4'd6: {kr, kc} = 4'b10_00;
            4'd7: {kr, kc} = 4'b10_01;
            4'd8: {kr, kc} = 4'b10_10;
            default: {kr, kc} = 4'b01_01;
        endcase
    end

    // Tap coordinates are signed so the -1 neighbour of column/row 0 is visible as negative.
    always_comb begin
        col_c = CW'(x) + CW'(kc) - CW'(1);
        row_c = CW'(y) + CW'(kr) - CW'(1);
`ifdef BORDER_REPLICATE_EN
        tap_addr = ADDR_W'($unsigned(clamp_coord(row_c, ROW_MAX))) * STRIDE
                 + ADDR_W'($unsigned(clamp_coord(col_c, COL_MAX)));
`else
        if (out_of_range(col_c, COL_MAX) || out_of_range(row_c, ROW_MAX))
            tap_addr = PAD;
        else
            tap_addr = ADDR_W'($unsigned(row_c)) * STRIDE + ADDR_W'($unsigned(col_c));
`endif
    end

    always_comb begin
        bus.en_in_mem     = 1'b0;
        bus.en_gray       = 1'b0;
        bus.en_sobel      = 1'b0;
        bus.en_shiftscale = 1'b0;
        bus.en_out_mem    = 1'b0;
        bus.busy          = 1'b1;
        bus.done          = 1'b0;
        case (state)
            S_IDLE:  bus.busy = 1'b0;
            S_FETCH: bus.en_in_mem = 1'b1;
            S_GRAY:  bus.en_gray = 1'b1;
            S_SOBEL: bus.en_sobel = 1'b1;
            S_SCALE: bus.en_shiftscale = 1'b1;
            S_WRITE: bus.en_out_mem = 1'b1;
            S_NEXT:  ;
            S_DONE: begin
                bus.busy = 1'b0;
                bus.done = 1'b1;
            end
            default: bus.busy = 1'b0;
        endcase
        bus.in_mem_addr  = (state == S_FETCH) ? tap_addr : '0;
        bus.gray_addr    = gray_addr;
        bus.out_mem_addr = out_addr;
    end
endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl on a 4x3 frame against a per-cycle behavioural model.
`timescale 1ns/1ps
module tb_window_scan_ctrl;
    localparam int W   = 4;
    localparam int H   = 3;
    localparam int N   = W * H;
    localparam int PAD = 12;
    localparam int AW  = 16;
    localparam int PIX = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    window_scan_ctrl_if #(.ADDR_W(AW)) bus ();

    window_scan_ctrl #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PAD_ADDR(PAD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    // Reference: a frame is a flat list of 22*N steps; step r of a pixel is
    // FETCH/GRAY pairs for taps 0..8, then SOBEL, SCALE, WRITE, NEXT.
    function automatic int exp_tap(input int px, input int py, input int k);
        int c, r;
        c = px + (k % 3) - 1;
        r = py + (k / 3) - 1;
`ifdef BORDER_REPLICATE_EN
        if (c < 0) c = 0;
        if (c > W - 1) c = W - 1;
        if (r < 0) r = 0;
        if (r > H - 1) r = H - 1;
        return r * W + c;
`else
        if (c < 0 || c > W - 1 || r < 0 || r > H - 1) return PAD;
        return r * W + c;
`endif
    endfunction

    function automatic bit step_is_fetch(input int idx);
        int r;
        r = idx % PIX;
        return (r < 18) && (r % 2 == 0);
    endfunction

    int m_mode = 0;  // 0 idle, 1 running, 2 done
    int m_idx  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_idx  <= 0;
        end else begin
            case (m_mode)
                0, 2: if (bus.start) begin
                    m_mode <= 1;
                    m_idx  <= 0;
                end
                default: begin
                    if (step_is_fetch(m_idx) && !bus.in_mem_ready) ;
                    else if (m_idx == PIX * N - 1) m_mode <= 2;
                    else m_idx <= m_idx + 1;
                end
            endcase
        end
    end

    int cap0 [9];
    int capl [9];
    int wr_seq [$];

    always @(negedge clk) begin
        int p, r;
        logic [6:0]  ectrl, actrl;
        logic [31:0] ein, eout, egray;
        bit gchk;
        gchk = 1'b1;
        ein = 0; eout = 0; egray = 0; ectrl = '0;
        p = m_idx / PIX;
        r = m_idx % PIX;
        if (m_mode == 0) begin
            ectrl = 7'b0000000;
        end else if (m_mode == 2) begin
            ectrl = 7'b0000001;
            eout  = N;
        end else begin
            eout = p;
            if (r < 18) begin
                egray = r / 2;
                if (r % 2 == 0) begin
                    ectrl = 7'b1000010;
                    ein   = exp_tap(p % W, p / W, r / 2);
                    if (p == 0)     cap0[r/2] = int'(bus.in_mem_addr);
                    if (p == N - 1) capl[r/2] = int'(bus.in_mem_addr);
                end else begin
                    ectrl = 7'b0100010;
                end
            end else if (r == 18) begin
                ectrl = 7'b0010010;
                gchk  = 1'b0;
            end else if (r == 19) begin
                ectrl = 7'b0001010;
            end else if (r == 20) begin
                ectrl = 7'b0000110;
            end else begin
                ectrl = 7'b0000010;
                eout  = p + 1;
            end
        end
        actrl = {bus.en_in_mem, bus.en_gray, bus.en_sobel, bus.en_shiftscale,
                 bus.en_out_mem, bus.busy, bus.done};
        check("ctrl", 32'(actrl), 32'(ectrl));
        check("in_mem_addr", 32'(bus.in_mem_addr), ein);
        check("out_mem_addr", 32'(bus.out_mem_addr), eout);
        if (gchk) check("gray_addr", 32'(bus.gray_addr), egray);
        if (bus.en_out_mem) wr_seq.push_back(int'(bus.out_mem_addr));
    end

    time t0;

    task automatic start_pulse();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        bit seen;
        seen = 1'b0;
        cycles = -1;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        else cycles = int'((($time - 5) - t0) / 10) + 1;
    endtask

    int lit0 [9];
    int litl [9];

    initial begin
        int cyc;
        bit found;
`ifdef BORDER_REPLICATE_EN
        lit0 = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
        litl = '{6, 7, 7, 10, 11, 11, 10, 11, 11};
`else
        lit0 = '{12, 12, 12, 12, 0, 1, 12, 4, 5};
        litl = '{6, 7, 12, 10, 11, 12, 12, 12, 12};
`endif
        bus.start = 1'b0;
        bus.in_mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", 32'({bus.en_in_mem, bus.en_gray, bus.en_sobel, bus.en_shiftscale,
                                 bus.en_out_mem, bus.busy, bus.done}), 32'd0);
        check("reset_out_addr", 32'(bus.out_mem_addr), 32'd0);

        // Plain frame: latency, edge taps and write address sequence.
        wr_seq.delete();
        start_pulse();
        wait_done(cyc);
        check("done_cycle", cyc, 265);
        for (int k = 0; k < 9; k++) check("tap_first_pixel", cap0[k], lit0[k]);
        for (int k = 0; k < 9; k++) check("tap_last_pixel", capl[k], litl[k]);
        check("write_count", wr_seq.size(), N);
        for (int i = 0; i < wr_seq.size(); i++) check("write_addr", wr_seq[i], i);

        // Memory not ready for the first three FETCH cycles.
        @(posedge clk); #1;
        bus.in_mem_ready = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.in_mem_ready = 1'b1;
        wait_done(cyc);
        check("done_cycle_stall", cyc, 268);

        // Reset in the middle of pixel 5.
        start_pulse();
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk); #1;
            if (m_mode == 1 && m_idx == 5 * PIX + 7) found = 1'b1;
        end
        check("reach_pixel5", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_ctrl", 32'({bus.en_in_mem, bus.en_gray, bus.en_sobel, bus.en_shiftscale,
                               bus.en_out_mem, bus.busy, bus.done}), 32'd0);
        check("rst_in_addr", 32'(bus.in_mem_addr), 32'd0);
        check("rst_out_addr", 32'(bus.out_mem_addr), 32'd0);
        check("rst_gray_addr", 32'(bus.gray_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        start_pulse();
        @(negedge clk);
        check("restart_fetch", 32'(bus.en_in_mem), 32'd1);
        check("restart_out_addr", 32'(bus.out_mem_addr), 32'd0);
        check("restart_tap0", 32'(bus.in_mem_addr), 32'(lit0[0]));
        wait_done(cyc);

        // start held high: ignored while busy, relaunches straight out of DONE.
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1;
        wait_done(cyc);
        @(negedge clk);
        check("held_start_refetch", 32'(bus.en_in_mem), 32'd1);
        check("held_start_out_addr", 32'(bus.out_mem_addr), 32'd0);
        check("held_start_done_low", 32'(bus.done), 32'd0);
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(cyc);

        // Random readiness and start pulses, checked cycle by cycle by the model.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            bus.in_mem_ready = ($urandom_range(0, 3) != 0);
            bus.start        = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_mem_ready = 1'b1;
        wait_done(cyc);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
